// File: rtl/if_pc_stage.sv
// Fetch-stage PC register and IF/ID pipeline register.
// PC is held as an offset from BASE_ADDR; ID_PC carries the physical address.
module if_pc_stage #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_3000,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] IM_BYTES     = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_PC,
  input  logic [31:0] IM_instr,
  input  logic        stall,
  input  logic        flush_ID,
  input  logic        Req,
  input  logic        is_branch_ID,
  output logic [31:0] IF_PC,
  output logic [31:0] ID_instr,
  output logic [31:0] ID_PC,
  output logic [4:0]  ID_ExcCode,
  output logic        ID_BD
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned EXC_W = 5;

  localparam logic [EXC_W-1:0] EXC_NONE    = EXC_W'(0);
  localparam logic [EXC_W-1:0] EXC_ADEL    = EXC_W'(4);
  localparam logic [XLEN-1:0]  HANDLER_OFS = XLEN'(HANDLER_ADDR - BASE_ADDR);

  logic [XLEN-1:0]  if_pc_q,    if_pc_d;
  logic [XLEN-1:0]  id_instr_q, id_instr_d;
  logic [XLEN-1:0]  id_pc_q,    id_pc_d;
  logic [EXC_W-1:0] id_exc_q,   id_exc_d;
  logic             id_bd_q,    id_bd_d;

  logic             adel_c;
  logic [XLEN-1:0]  fetch_word_c;
  logic [XLEN-1:0]  if_phys_c;

  // Fetch address check: misaligned or outside the instruction-memory window
  always_comb begin
    adel_c       = (if_pc_q[1:0] != 2'b00) || (if_pc_q >= IM_BYTES);
    fetch_word_c = adel_c ? '0 : IM_instr;
    if_phys_c    = if_pc_q + BASE_ADDR;
  end

  // Next-state selection, priority Req > stall > flush_ID > normal
  always_comb begin
    if_pc_d    = if_pc_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_exc_d   = id_exc_q;
    id_bd_d    = id_bd_q;
    if (Req) begin
      if_pc_d    = HANDLER_OFS;
      id_instr_d = '0;
      id_pc_d    = HANDLER_ADDR;
      id_exc_d   = EXC_NONE;
      id_bd_d    = 1'b0;
    end else if (stall) begin
      // hold everything
    end else if (flush_ID) begin
      if_pc_d    = next_PC;
      id_instr_d = '0;
      id_pc_d    = if_phys_c;
      id_exc_d   = EXC_NONE;
      id_bd_d    = 1'b0;
    end else begin
      if_pc_d    = next_PC;
      id_instr_d = fetch_word_c;
      id_pc_d    = if_phys_c;
      id_exc_d   = adel_c ? EXC_ADEL : EXC_NONE;
      id_bd_d    = is_branch_ID;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_pc_q    <= '0;
      id_instr_q <= '0;
      id_pc_q    <= BASE_ADDR;
      id_exc_q   <= EXC_NONE;
      id_bd_q    <= 1'b0;
    end else begin
      if_pc_q    <= if_pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_exc_q   <= id_exc_d;
      id_bd_q    <= id_bd_d;
    end
  end

  assign IF_PC      = if_pc_q;
  assign ID_instr   = id_instr_q;
  assign ID_PC      = id_pc_q;
  assign ID_ExcCode = id_exc_q;
  assign ID_BD      = id_bd_q;

endmodule

// File: tb/tb_if_pc_stage.sv
// Directed bench for if_pc_stage: sequential fetch, stall, Req redirect,
// AdEL fetch faults, delay-slot flag, flush and asynchronous reset.
module tb_if_pc_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_PC;
  logic [31:0] IM_instr;
  logic        stall;
  logic        flush_ID;
  logic        Req;
  logic        is_branch_ID;
  logic [31:0] IF_PC;
  logic [31:0] ID_instr;
  logic [31:0] ID_PC;
  logic [4:0]  ID_ExcCode;
  logic        ID_BD;

  int checks = 0;
  int errors = 0;

  if_pc_stage dut (
    .clk          (clk),
    .reset        (reset),
    .next_PC      (next_PC),
    .IM_instr     (IM_instr),
    .stall        (stall),
    .flush_ID     (flush_ID),
    .Req          (Req),
    .is_branch_ID (is_branch_ID),
    .IF_PC        (IF_PC),
    .ID_instr     (ID_instr),
    .ID_PC        (ID_PC),
    .ID_ExcCode   (ID_ExcCode),
    .ID_BD        (ID_BD)
  );

  always #5 clk = ~clk;

  // Instruction memory model: word content tagged with its offset
  assign IM_instr = 32'hA500_0000 ^ IF_PC;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [4:0] exc, input logic bd);
    check({tag, ".instr"}, ID_instr, instr);
    check({tag, ".pc"},    ID_PC, pc);
    check({tag, ".exc"},   32'(ID_ExcCode), 32'(exc));
    check({tag, ".bd"},    32'(ID_BD), 32'(bd));
  endtask

  initial begin
    reset = 1'b1; next_PC = '0; stall = 1'b0; flush_ID = 1'b0;
    Req = 1'b0; is_branch_ID = 1'b0;
    #2;
    check("rst.if_pc", IF_PC, 32'h0);
    check_id("rst", 32'h0, 32'h3000, 5'd0, 1'b0);
    #6 reset = 1'b0;

    // 1: sequential fetch from BASE_ADDR
    for (int i = 0; i < 4; i++) begin
      next_PC = IF_PC + 32'd4;
      tick();
      check_id($sformatf("seq%0d", i), 32'hA500_0000 ^ (32'(i) * 32'd4),
               32'h3000 + 32'(i) * 32'd4, 5'd0, 1'b0);
    end
    check("seq.if_pc", IF_PC, 32'h10);

    // 2: stall holds PC and IF/ID for three cycles
    stall = 1'b1; next_PC = 32'h14;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d.if_pc", i), IF_PC, 32'h10);
      check_id($sformatf("stall%0d", i), 32'hA500_000C, 32'h300C, 5'd0, 1'b0);
    end
    stall = 1'b0;
    tick();
    check("unstall.if_pc", IF_PC, 32'h14);
    check_id("unstall", 32'hA500_0010, 32'h3010, 5'd0, 1'b0);

    // 3: Req overrides stall
    stall = 1'b1; Req = 1'b1; is_branch_ID = 1'b1; next_PC = 32'h18;
    tick();
    check("req.if_pc", IF_PC, 32'h1180);
    check_id("req", 32'h0, 32'h4180, 5'd0, 1'b0);
    stall = 1'b0; Req = 1'b0; is_branch_ID = 1'b0;

    // 4: misaligned and out-of-window fetches raise AdEL
    next_PC = 32'h2;
    tick();
    check_id("handler", 32'hA500_1180, 32'h4180, 5'd0, 1'b0);
    next_PC = 32'h4000;
    tick();
    check("mis.if_pc", IF_PC, 32'h4000);
    check_id("mis", 32'h0, 32'h3002, 5'd4, 1'b0);
    next_PC = 32'h8;
    tick();
    check_id("oow", 32'h0, 32'h7000, 5'd4, 1'b0);
    next_PC = 32'h3FFC;
    tick();
    check_id("ok8", 32'hA500_0008, 32'h3008, 5'd0, 1'b0);
    next_PC = 32'h0;
    tick();
    check_id("last", 32'hA500_3FFC, 32'h6FFC, 5'd0, 1'b0);

    // 5: delay-slot flag, then flush clears it
    is_branch_ID = 1'b1; next_PC = 32'h4;
    tick();
    check_id("bd", 32'hA500_0000, 32'h3000, 5'd0, 1'b1);
    flush_ID = 1'b1; next_PC = 32'h8;
    tick();
    check("flush.if_pc", IF_PC, 32'h8);
    check_id("flush", 32'h0, 32'h3004, 5'd0, 1'b0);
    flush_ID = 1'b0; is_branch_ID = 1'b0;

    // 6: asynchronous reset mid-stall
    stall = 1'b1; next_PC = 32'h20;
    tick();
    check("prerst.if_pc", IF_PC, 32'h8);
    reset = 1'b1;
    #2;
    check("arst.if_pc", IF_PC, 32'h0);
    check_id("arst", 32'h0, 32'h3000, 5'd0, 1'b0);
    #1 reset = 1'b0; stall = 1'b0; next_PC = 32'h4;
    tick();
    check("restart.if_pc", IF_PC, 32'h4);
    check_id("restart", 32'hA500_0000, 32'h3000, 5'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
